wb_select_pipe: RTL and testbench
=================================

Name: wb_select_pipe

Overview:
Parametrised, registered N-source write-back select stage for the register-file write port. Each accepted transfer latches the source selected by Sel out of NUM_SRC candidates (ALU result, memory read data, immediate, PC+1, ...) into a 2-entry skid buffer. The buffer drives WriteData to the register file over a valid/ready handshake, so the write-back path can absorb one cycle of register-file stall without losing data.
Also keeps a sticky illegal-select flag and a wrapping count of completed writes for debug.

Parameters:
WIDTH, 16, data width of each source and of WriteData
NUM_SRC, 4, number of candidate sources (2..16)
SEL_W, $clog2(NUM_SRC) (min 1), width of Sel
CNT_W, 16, width of XferCount

Ports:
Clk  in  1  system clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Sel  in  SEL_W  source index for the current input transfer
SrcData  in  NUM_SRC*WIDTH  packed sources; source k = SrcData[k*WIDTH +: WIDTH]
InValid  in  1  upstream presents Sel/SrcData this cycle
InReady  out  1  stage can accept an input transfer this cycle
WriteData  out  WIDTH  selected data at buffer head
WriteSel  out  SEL_W  Sel value captured with the head entry
OutValid  out  1  head entry valid
OutReady  in  1  register file consumes head this cycle
SelErr  out  1  sticky: an out-of-range Sel was accepted
XferCount  out  CNT_W  number of completed output transfers, wraps

Behaviour:
- Single clock domain. Reset is synchronous and active-high: sampled only on the Clk rising edge.
- Reset (synchronous) clears: occupancy=0, OutValid=0, WriteData=0, WriteSel=0, SelErr=0, XferCount=0. Any handshake during a reset cycle is ignored: no push, no pop, no count.
- Reset mid-operation discards all buffered entries.
- Occupancy: 0, 1 or 2 entries, FIFO order, held in two entry registers (head, tail).
- InReady = (occupancy != 2). It is combinational from registered state only and never depends on InValid or OutReady.
- Push = InValid & InReady. Pop = OutValid & OutReady.
- Push captures {Sel, selected source}.
  - If Sel < NUM_SRC, the selected source is SrcData[Sel*WIDTH +: WIDTH].
  - If Sel >= NUM_SRC (only possible for non-power-of-two NUM_SRC), the captured data is 0 and SelErr is set on that edge.
  - SelErr stays set until Reset.
- Latency: data pushed at edge t is visible on WriteData with OutValid=1 after edge t (one cycle). There is no combinational path from inputs to WriteData.
- OutValid = (occupancy != 0). WriteData and WriteSel always show the head entry. When empty they hold their last values (0 after reset).
- Occupancy transitions:
  - 0, push -> 1.
  - 1, push & pop -> 1: the new entry becomes head on the same edge.
  - 1, push only -> 2.
  - 1, pop only -> 0.
  - 2, pop -> 1: tail moves to head. Push is impossible at 2.
  - No push and no pop -> unchanged.
- Stability: while OutValid=1 and OutReady=0, WriteData/WriteSel hold stable. Later pushes go to the tail only.
- XferCount increments by 1 on every Pop, modulo 2^CNT_W. The value after 2^CNT_W-1 is 0.
- No bubble: with OutReady held at 1 and InValid held at 1, one transfer completes every cycle after the first.

Test Plan:
- Reset/idle: assert Reset for 2 cycles with InValid=1, Sel=1 -> afterwards OutValid=0, WriteData=0, SelErr=0, XferCount=0, InReady=1.
- Single transfer (WIDTH=16, NUM_SRC=4): SrcData={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, Sel=2, InValid pulse with OutReady=1 -> next cycle WriteData=16'hCCCC, WriteSel=2, OutValid=1. One cycle later OutValid=0 and XferCount=1.
- Back-pressure/full: OutReady=0, push Sel=0 then Sel=3 -> InReady=0 after the 2nd push and a 3rd InValid is ignored. WriteData stays 16'hAAAA. Raise OutReady -> outputs 16'hAAAA, then 16'hDDDD, XferCount=2.
- Streaming: OutReady=1, InValid=1 for 20 cycles, Sel cycling 0..3 -> 20 outputs in order with no idle cycles, XferCount=20.
- Illegal select (NUM_SRC=3, SEL_W=2): push Sel=3 -> WriteData=0, SelErr=1. SelErr remains 1 through later legal transfers until Reset.
- Reset mid-operation with occupancy=2 -> next cycle OutValid=0 and InReady=1; the dropped entries never appear on WriteData.

Source files
------------

// File: rtl/wb_select_pipe_if.sv
// Handshake bundle between the write-back select stage and its neighbours.
// The master side drives selection and sources; the slave side is the stage.
interface wb_select_pipe_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int CNT_W   = 16
);
    logic [SEL_W-1:0]         Sel;
    logic [NUM_SRC*WIDTH-1:0] SrcData;
    logic                     InValid;
    logic                     InReady;
    logic [WIDTH-1:0]         WriteData;
    logic [SEL_W-1:0]         WriteSel;
    logic                     OutValid;
    logic                     OutReady;
    logic                     SelErr;
    logic [CNT_W-1:0]         XferCount;

    modport master (
        output Sel, SrcData, InValid, OutReady,
        input  InReady, WriteData, WriteSel, OutValid, SelErr, XferCount
    );

    modport slave (
        input  Sel, SrcData, InValid, OutReady,
        output InReady, WriteData, WriteSel, OutValid, SelErr, XferCount
    );
endinterface

// File: rtl/wb_select_pipe.sv
// Registered N-source write-back select with a 2-entry skid buffer feeding
// the register-file write port; also tracks illegal selects and write count.
module wb_select_pipe #(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int CNT_W   = 16
) (
    input logic              Clk,
    input logic              Reset,
    wb_select_pipe_if.slave  bus
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic [SEL_W-1:0] head_sel_q, head_sel_d;
    logic [SEL_W-1:0] tail_sel_q, tail_sel_d;
    logic             sel_err_q, sel_err_d;
    logic [CNT_W-1:0] xfer_q, xfer_d;

    logic             in_ready;
    logic             out_valid;
    logic             push;
    logic             pop;
    logic             sel_legal;
    logic [WIDTH-1:0] pick_data;

    // Out-of-range selects fall through the loop and capture zero.
    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.Sel == SEL_W'(k)) begin
                pick_data = bus.SrcData[k*WIDTH +: WIDTH];
            end
        end
        sel_legal = ({1'b0, bus.Sel} < (SEL_W+1)'(NUM_SRC));
    end

    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign push      = bus.InValid & in_ready;
    assign pop       = out_valid & bus.OutReady;

    assign bus.InReady   = in_ready;
    assign bus.OutValid  = out_valid;
    assign bus.WriteData = head_data_q;
    assign bus.WriteSel  = head_sel_q;
    assign bus.SelErr    = sel_err_q;
    assign bus.XferCount = xfer_q;

    always_comb begin
        occ_d       = occ_q;
        head_data_d = head_data_q;
        head_sel_d  = head_sel_q;
        tail_data_d = tail_data_q;
        tail_sel_d  = tail_sel_q;
        sel_err_d   = sel_err_q | (push & ~sel_legal);
        xfer_d      = pop ? xfer_q + CNT_W'(1) : xfer_q;

        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_data_d = pick_data;
                    head_sel_d  = bus.Sel;
                    occ_d       = OCC_ONE;
                end
            end
            OCC_ONE: begin
                // Push with pop replaces the head directly so streaming has no bubble.
                if (push && pop) begin
                    head_data_d = pick_data;
                    head_sel_d  = bus.Sel;
                end else if (push) begin
                    tail_data_d = pick_data;
                    tail_sel_d  = bus.Sel;
                    occ_d       = OCC_FULL;
                end else if (pop) begin
                    occ_d       = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_sel_d  = tail_sel_q;
                    occ_d       = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            occ_q       <= OCC_EMPTY;
            head_data_q <= '0;
            head_sel_q  <= '0;
            tail_data_q <= '0;
            tail_sel_q  <= '0;
            sel_err_q   <= 1'b0;
            xfer_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            head_data_q <= head_data_d;
            head_sel_q  <= head_sel_d;
            tail_data_q <= tail_data_d;
            tail_sel_q  <= tail_sel_d;
            sel_err_q   <= sel_err_d;
            xfer_q      <= xfer_d;
        end
    end

endmodule

// File: tb/tb_wb_select_pipe.sv
// Bench for wb_select_pipe: a 4-source instance and a 3-source instance with a
// narrow counter, both compared every cycle against an array-based FIFO model.
module tb_wb_select_pipe;

    logic Clk = 1'b0;
    logic Reset;

    always #5 Clk = ~Clk;

    wb_select_pipe_if #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .CNT_W(16)) bus_a ();
    wb_select_pipe_if #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .CNT_W(4))  bus_b ();

    wb_select_pipe #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2), .CNT_W(16)) dut_a (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_a)
    );

    wb_select_pipe #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2), .CNT_W(4)) dut_b (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus_b)
    );

    logic        in_valid  [2];
    logic [1:0]  sel       [2];
    logic        out_ready [2];
    logic [15:0] src       [2][4];

    assign bus_a.InValid  = in_valid[0];
    assign bus_a.Sel      = sel[0];
    assign bus_a.OutReady = out_ready[0];
    assign bus_a.SrcData  = {src[0][3], src[0][2], src[0][1], src[0][0]};
    assign bus_b.InValid  = in_valid[1];
    assign bus_b.Sel      = sel[1];
    assign bus_b.OutReady = out_ready[1];
    assign bus_b.SrcData  = {src[1][2], src[1][1], src[1][0]};

    // Reference: occupancy count plus a two-slot array kept in FIFO order.
    int          m_cnt       [2];
    logic [15:0] m_data      [2][2];
    logic [1:0]  m_sel       [2][2];
    logic [15:0] m_last_data [2];
    logic [1:0]  m_last_sel  [2];
    logic        m_err       [2];
    int          m_xfer      [2];

    int checks   = 0;
    int failures = 0;

    function automatic int nSrc(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int cntMod(input int d);
        return (d == 0) ? 65536 : 16;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic v, input logic [1:0] s, input logic r);
        in_valid[d]  = v;
        sel[d]       = s;
        out_ready[d] = r;
    endtask

    task automatic tick();
        bit          do_push [2];
        bit          do_pop  [2];
        logic [15:0] new_data[2];
        for (int d = 0; d < 2; d++) begin
            do_push[d]  = !Reset && in_valid[d] && (m_cnt[d] != 2);
            do_pop[d]   = !Reset && out_ready[d] && (m_cnt[d] != 0);
            new_data[d] = (int'(sel[d]) < nSrc(d)) ? src[d][sel[d]] : 16'h0000;
        end
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (Reset) begin
                m_cnt[d]       = 0;
                m_last_data[d] = '0;
                m_last_sel[d]  = '0;
                m_err[d]       = 1'b0;
                m_xfer[d]      = 0;
            end else begin
                if (do_pop[d]) begin
                    m_data[d][0] = m_data[d][1];
                    m_sel[d][0]  = m_sel[d][1];
                    m_cnt[d]     = m_cnt[d] - 1;
                    m_xfer[d]    = (m_xfer[d] + 1) % cntMod(d);
                end
                if (do_push[d]) begin
                    m_data[d][m_cnt[d]] = new_data[d];
                    m_sel[d][m_cnt[d]]  = sel[d];
                    m_cnt[d]            = m_cnt[d] + 1;
                    if (int'(sel[d]) >= nSrc(d)) m_err[d] = 1'b1;
                end
                if (m_cnt[d] > 0) begin
                    m_last_data[d] = m_data[d][0];
                    m_last_sel[d]  = m_sel[d][0];
                end
            end
        end
        #2;
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, ".a.rdy"},  32'(bus_a.InReady),   32'(m_cnt[0] != 2));
        cmp({tag, ".a.vld"},  32'(bus_a.OutValid),  32'(m_cnt[0] != 0));
        cmp({tag, ".a.data"}, 32'(bus_a.WriteData), 32'(m_last_data[0]));
        cmp({tag, ".a.sel"},  32'(bus_a.WriteSel),  32'(m_last_sel[0]));
        cmp({tag, ".a.err"},  32'(bus_a.SelErr),    32'(m_err[0]));
        cmp({tag, ".a.cnt"},  32'(bus_a.XferCount), 32'(m_xfer[0]));
        cmp({tag, ".b.rdy"},  32'(bus_b.InReady),   32'(m_cnt[1] != 2));
        cmp({tag, ".b.vld"},  32'(bus_b.OutValid),  32'(m_cnt[1] != 0));
        cmp({tag, ".b.data"}, 32'(bus_b.WriteData), 32'(m_last_data[1]));
        cmp({tag, ".b.sel"},  32'(bus_b.WriteSel),  32'(m_last_sel[1]));
        cmp({tag, ".b.err"},  32'(bus_b.SelErr),    32'(m_err[1]));
        cmp({tag, ".b.cnt"},  32'(bus_b.XferCount), 32'(m_xfer[1]));
    endtask

    initial begin
        int xfer_start;

        for (int d = 0; d < 2; d++) begin
            m_cnt[d]       = 0;
            m_last_data[d] = '0;
            m_last_sel[d]  = '0;
            m_err[d]       = 1'b0;
            m_xfer[d]      = 0;
            m_data[d][0]   = '0;
            m_data[d][1]   = '0;
            m_sel[d][0]    = '0;
            m_sel[d][1]    = '0;
        end
        src[0][0] = 16'hAAAA; src[0][1] = 16'hBBBB; src[0][2] = 16'hCCCC; src[0][3] = 16'hDDDD;
        src[1][0] = 16'h1111; src[1][1] = 16'h2222; src[1][2] = 16'h3333; src[1][3] = 16'h4444;

        // Reset with a handshake presented: nothing may be captured.
        Reset = 1'b1;
        applyStimulus(0, 1'b1, 2'd1, 1'b1);
        applyStimulus(1, 1'b1, 2'd1, 1'b1);
        #1;
        tick();
        tick();
        Reset = 1'b0;
        applyStimulus(0, 1'b0, 2'd1, 1'b0);
        applyStimulus(1, 1'b0, 2'd1, 1'b0);
        checkOutput("reset");
        cmp("reset.a.vld.const", 32'(bus_a.OutValid), 32'd0);
        cmp("reset.a.rdy.const", 32'(bus_a.InReady), 32'd1);

        // Single transfer from source 2.
        applyStimulus(0, 1'b1, 2'd2, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        checkOutput("single.t1");
        cmp("single.data.const", 32'(bus_a.WriteData), 32'h0000CCCC);
        cmp("single.sel.const",  32'(bus_a.WriteSel),  32'd2);
        tick();
        checkOutput("single.t2");
        cmp("single.cnt.const", 32'(bus_a.XferCount), 32'd1);

        // Back-pressure: fill, try a third push, then drain.
        applyStimulus(0, 1'b1, 2'd0, 1'b0);
        tick();
        checkOutput("bp.push0");
        applyStimulus(0, 1'b1, 2'd3, 1'b0);
        tick();
        checkOutput("bp.push3");
        cmp("bp.full.rdy.const", 32'(bus_a.InReady), 32'd0);
        applyStimulus(0, 1'b1, 2'd1, 1'b0);
        tick();
        checkOutput("bp.ignored");
        cmp("bp.hold.const", 32'(bus_a.WriteData), 32'h0000AAAA);
        applyStimulus(0, 1'b0, 2'd1, 1'b1);
        tick();
        checkOutput("bp.drain1");
        cmp("bp.second.const", 32'(bus_a.WriteData), 32'h0000DDDD);
        tick();
        checkOutput("bp.drain2");
        cmp("bp.cnt.const", 32'(bus_a.XferCount), 32'd3);

        // Streaming with no bubbles.
        xfer_start = m_xfer[0];
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 1'b1, 2'(i % 4), 1'b1);
            tick();
            checkOutput("stream");
            if (i > 0) cmp("stream.novalidgap", 32'(bus_a.OutValid), 32'd1);
        end
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("stream.end");
        cmp("stream.count", 32'(bus_a.XferCount), 32'(xfer_start + 20));

        // Illegal select on the 3-source instance.
        applyStimulus(1, 1'b1, 2'd3, 1'b1);
        tick();
        applyStimulus(1, 1'b1, 2'd1, 1'b1);
        checkOutput("illegal");
        cmp("illegal.data.const", 32'(bus_b.WriteData), 32'd0);
        cmp("illegal.err.const",  32'(bus_b.SelErr),    32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("illegal.after");
        end
        applyStimulus(1, 1'b0, 2'd0, 1'b1);
        tick();
        checkOutput("illegal.idle");
        cmp("illegal.sticky.const", 32'(bus_b.SelErr), 32'd1);

        // Reset while the buffer is full.
        applyStimulus(0, 1'b1, 2'd1, 1'b0);
        tick();
        applyStimulus(0, 1'b1, 2'd2, 1'b0);
        tick();
        checkOutput("midrst.full");
        Reset = 1'b1;
        applyStimulus(0, 1'b0, 2'd0, 1'b1);
        tick();
        Reset = 1'b0;
        checkOutput("midrst.after");
        cmp("midrst.vld.const", 32'(bus_a.OutValid), 32'd0);
        cmp("midrst.rdy.const", 32'(bus_a.InReady), 32'd1);
        tick();
        checkOutput("midrst.quiet");

        // Random traffic, occasional resets; the 4-bit counter on b wraps here.
        for (int i = 0; i < 600; i++) begin
            Reset = ($urandom_range(0, 99) == 0);
            for (int d = 0; d < 2; d++) begin
                applyStimulus(d, 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                              1'($urandom_range(0, 3) != 0));
                for (int k = 0; k < 4; k++) src[d][k] = 16'($urandom);
            end
            tick();
            checkOutput("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
